// File: rtl/sram_stage_sequencer.sv
// Top-level stage scheduler: hands the single SRAM port to UART load, M1, M2 and VGA in turn,
// detects end of UART load by write inactivity and guards compute stages with a watchdog.
module sram_stage_sequencer #(
    parameter int unsigned UART_TIMEOUT  = 50_000_000,
    parameter int unsigned STAGE_TIMEOUT = 0,
    parameter bit          SKIP_M2       = 1'b0
) (
    input  logic        CLOCK_50_I,
    input  logic        Resetn,
    input  logic        start_i,
    input  logic [17:0] uart_address_i,
    input  logic [15:0] uart_wdata_i,
    input  logic        uart_we_n_i,
    input  logic [17:0] m1_address_i,
    input  logic [15:0] m1_wdata_i,
    input  logic        m1_we_n_i,
    input  logic [17:0] m2_address_i,
    input  logic [15:0] m2_wdata_i,
    input  logic        m2_we_n_i,
    input  logic [17:0] vga_address_i,
    input  logic        m1_done_i,
    input  logic        m2_done_i,
    output logic        uart_init_o,
    output logic        uart_enable_o,
    output logic        m1_start_o,
    output logic        m2_start_o,
    output logic        vga_enable_o,
    output logic [17:0] SRAM_address,
    output logic [15:0] SRAM_write_data,
    output logic        SRAM_we_n,
    output logic [2:0]  stage_o,
    output logic        error_o
);

    localparam int unsigned UART_TW = 26;
    localparam int unsigned WD_TW   = 32;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_UART_ARM = 3'd1,
        S_UART_RX  = 3'd2,
        S_M1       = 3'd3,
        S_M2       = 3'd4,
        S_VGA      = 3'd5,
        S_ERR      = 3'd6
    } state_t;

    state_t               state, state_nxt;
    logic [UART_TW-1:0]   uart_timer, uart_timer_nxt;
    logic [WD_TW-1:0]     wd_timer, wd_timer_nxt;
    logic                 write_seen, write_seen_nxt;
    logic                 uart_init_nxt, uart_enable_nxt, m1_start_nxt, m2_start_nxt;
    logic                 vga_enable_nxt, error_nxt;
    logic                 uart_idle_done, wd_expired;

    assign uart_idle_done = write_seen && (uart_timer == UART_TW'(UART_TIMEOUT - 1));
    assign wd_expired     = (STAGE_TIMEOUT != 0) && (wd_timer == WD_TW'(STAGE_TIMEOUT - 1));
    assign stage_o        = state;

    // State, timers and registered handshake outputs
    always_ff @(posedge CLOCK_50_I or negedge Resetn) begin
        if (!Resetn) begin
            state         <= S_IDLE;
            uart_timer    <= '0;
            wd_timer      <= '0;
            write_seen    <= 1'b0;
            uart_init_o   <= 1'b0;
            uart_enable_o <= 1'b0;
            m1_start_o    <= 1'b0;
            m2_start_o    <= 1'b0;
            vga_enable_o  <= 1'b0;
            error_o       <= 1'b0;
        end else begin
            state         <= state_nxt;
            uart_timer    <= uart_timer_nxt;
            wd_timer      <= wd_timer_nxt;
            write_seen    <= write_seen_nxt;
            uart_init_o   <= uart_init_nxt;
            uart_enable_o <= uart_enable_nxt;
            m1_start_o    <= m1_start_nxt;
            m2_start_o    <= m2_start_nxt;
            vga_enable_o  <= vga_enable_nxt;
            error_o       <= error_nxt;
        end
    end

    // Next-state and next-output logic; a done pulse beats a same-cycle watchdog expiry
    always_comb begin
        state_nxt       = state;
        uart_timer_nxt  = uart_timer;
        wd_timer_nxt    = wd_timer;
        write_seen_nxt  = write_seen;
        uart_init_nxt   = 1'b0;
        uart_enable_nxt = 1'b0;
        m1_start_nxt    = 1'b0;
        m2_start_nxt    = 1'b0;
        vga_enable_nxt  = vga_enable_o;
        error_nxt       = error_o;
        case (state)
            S_IDLE: begin
                if (start_i) begin
                    state_nxt     = S_UART_ARM;
                    uart_init_nxt = 1'b1;
                end
            end
            S_UART_ARM: begin
                state_nxt       = S_UART_RX;
                uart_enable_nxt = 1'b1;
                uart_timer_nxt  = '0;
                write_seen_nxt  = 1'b0;
            end
            S_UART_RX: begin
                if (!uart_we_n_i) begin
                    uart_timer_nxt = '0;
                    write_seen_nxt = 1'b1;
                end else begin
                    uart_timer_nxt = uart_timer + UART_TW'(1);
                    if (uart_idle_done) begin
                        state_nxt     = S_M1;
                        uart_init_nxt = 1'b1;
                        m1_start_nxt  = 1'b1;
                        wd_timer_nxt  = '0;
                    end
                end
            end
            S_M1: begin
                wd_timer_nxt = wd_timer + WD_TW'(1);
                if (m1_done_i) begin
                    if (SKIP_M2) begin
                        state_nxt      = S_VGA;
                        vga_enable_nxt = 1'b1;
                    end else begin
                        state_nxt    = S_M2;
                        m2_start_nxt = 1'b1;
                        wd_timer_nxt = '0;
                    end
                end else if (wd_expired) begin
                    state_nxt = S_ERR;
                    error_nxt = 1'b1;
                end
            end
            S_M2: begin
                wd_timer_nxt = wd_timer + WD_TW'(1);
                if (m2_done_i) begin
                    state_nxt      = S_VGA;
                    vga_enable_nxt = 1'b1;
                end else if (wd_expired) begin
                    state_nxt = S_ERR;
                    error_nxt = 1'b1;
                end
            end
            S_VGA:   vga_enable_nxt = 1'b1;
            S_ERR:   state_nxt = S_ERR;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Zero-latency SRAM ownership mux; non-owning states never write
    always_comb begin
        SRAM_address    = '0;
        SRAM_write_data = '0;
        SRAM_we_n       = 1'b1;
        case (state)
            S_UART_ARM, S_UART_RX: begin
                SRAM_address    = uart_address_i;
                SRAM_write_data = uart_wdata_i;
                SRAM_we_n       = uart_we_n_i;
            end
            S_M1: begin
                SRAM_address    = m1_address_i;
                SRAM_write_data = m1_wdata_i;
                SRAM_we_n       = m1_we_n_i;
            end
            S_M2: begin
                SRAM_address    = m2_address_i;
                SRAM_write_data = m2_wdata_i;
                SRAM_we_n       = m2_we_n_i;
            end
            S_VGA:   SRAM_address = vga_address_i;
            default: SRAM_address = '0;
        endcase
    end

endmodule

// File: tb/tb_sram_stage_sequencer.sv
// Directed bench for sram_stage_sequencer: one SKIP_M2=0 and one SKIP_M2=1 instance on shared stimulus.
module tb_sram_stage_sequencer;

    logic        clk, rst_n, start;
    logic [17:0] uart_addr, m1_addr, m2_addr, vga_addr;
    logic [15:0] uart_wdata, m1_wdata, m2_wdata;
    logic        uart_we_n, m1_we_n, m2_we_n, m1_done, m2_done;

    logic        uart_init, uart_enable, m1_start, m2_start, vga_en, sram_we_n, error;
    logic [17:0] sram_addr;
    logic [15:0] sram_wdata;
    logic [2:0]  stage;

    logic        b_uart_init, b_uart_enable, b_m1_start, b_m2_start, b_vga_en, b_sram_we_n, b_error;
    logic [17:0] b_sram_addr;
    logic [15:0] b_sram_wdata;
    logic [2:0]  b_stage;

    int checks = 0;
    int errors = 0;
    int m1_cnt, m2_cnt, init_cnt, en_cnt, b_m2_cnt;

    sram_stage_sequencer #(.UART_TIMEOUT(8), .STAGE_TIMEOUT(100), .SKIP_M2(1'b0)) dut_a (
        .CLOCK_50_I(clk), .Resetn(rst_n), .start_i(start),
        .uart_address_i(uart_addr), .uart_wdata_i(uart_wdata), .uart_we_n_i(uart_we_n),
        .m1_address_i(m1_addr), .m1_wdata_i(m1_wdata), .m1_we_n_i(m1_we_n),
        .m2_address_i(m2_addr), .m2_wdata_i(m2_wdata), .m2_we_n_i(m2_we_n),
        .vga_address_i(vga_addr), .m1_done_i(m1_done), .m2_done_i(m2_done),
        .uart_init_o(uart_init), .uart_enable_o(uart_enable), .m1_start_o(m1_start),
        .m2_start_o(m2_start), .vga_enable_o(vga_en), .SRAM_address(sram_addr),
        .SRAM_write_data(sram_wdata), .SRAM_we_n(sram_we_n), .stage_o(stage), .error_o(error)
    );

    sram_stage_sequencer #(.UART_TIMEOUT(8), .STAGE_TIMEOUT(100), .SKIP_M2(1'b1)) dut_b (
        .CLOCK_50_I(clk), .Resetn(rst_n), .start_i(start),
        .uart_address_i(uart_addr), .uart_wdata_i(uart_wdata), .uart_we_n_i(uart_we_n),
        .m1_address_i(m1_addr), .m1_wdata_i(m1_wdata), .m1_we_n_i(m1_we_n),
        .m2_address_i(m2_addr), .m2_wdata_i(m2_wdata), .m2_we_n_i(m2_we_n),
        .vga_address_i(vga_addr), .m1_done_i(m1_done), .m2_done_i(m2_done),
        .uart_init_o(b_uart_init), .uart_enable_o(b_uart_enable), .m1_start_o(b_m1_start),
        .m2_start_o(b_m2_start), .vga_enable_o(b_vga_en), .SRAM_address(b_sram_addr),
        .SRAM_write_data(b_sram_wdata), .SRAM_we_n(b_sram_we_n), .stage_o(b_stage), .error_o(b_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse counters sampled mid-cycle
    always @(negedge clk) begin
        if (m1_start)    m1_cnt++;
        if (m2_start)    m2_cnt++;
        if (uart_init)   init_cnt++;
        if (uart_enable) en_cnt++;
        if (b_m2_start)  b_m2_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; start = 1'b0;
        uart_addr = '0; m1_addr = '0; m2_addr = '0; vga_addr = '0;
        uart_wdata = '0; m1_wdata = '0; m2_wdata = '0;
        uart_we_n = 1'b1; m1_we_n = 1'b1; m2_we_n = 1'b1;
        m1_done = 1'b0; m2_done = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        m1_cnt = 0; m2_cnt = 0; init_cnt = 0; en_cnt = 0; b_m2_cnt = 0;
        tick();
    endtask

    // start -> ARM -> RX, with n writes spaced 2 cycles, then the 8-cycle idle timeout into M1
    task automatic run_to_m1(input int n);
        start = 1'b1; tick(); start = 1'b0;
        checks++;
        if (stage !== 3'd1 || uart_init !== 1'b1) begin
            errors++; $display("FAIL arm_entry: stage=%0d init=%0b want 1/1", stage, uart_init);
        end
        tick();
        checks++;
        if (stage !== 3'd2 || uart_enable !== 1'b1 || uart_init !== 1'b0) begin
            errors++; $display("FAIL rx_entry: stage=%0d en=%0b init=%0b want 2/1/0", stage, uart_enable, uart_init);
        end
        for (int i = 0; i < n; i++) begin
            uart_addr = 18'(18'h100 + i); uart_wdata = 16'(16'hA000 + i);
            uart_we_n = 1'b0; tick(); uart_we_n = 1'b1;
            if (i < n - 1) tick();
        end
        repeat (7) tick();
        checks++;
        if (stage !== 3'd2) begin
            errors++; $display("FAIL load_early: stage=%0d want 2", stage);
        end
        tick();
        checks++;
        if (stage !== 3'd3 || m1_start !== 1'b1 || uart_init !== 1'b1) begin
            errors++; $display("FAIL m1_entry: stage=%0d m1_start=%0b init=%0b want 3/1/1", stage, m1_start, uart_init);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; #1;
        checks++;
        if (stage !== 3'd0 || error !== 1'b0 || vga_en !== 1'b0 || sram_we_n !== 1'b1 ||
            sram_addr !== 18'd0 || uart_init !== 1'b0 || m1_start !== 1'b0) begin
            errors++; $display("FAIL reset_state: stage=%0d err=%0b vga=%0b we_n=%0b addr=%0h want 0/0/0/1/0",
                               stage, error, vga_en, sram_we_n, sram_addr);
        end
        do_reset();
    endtask

    task automatic test_happy_path();
        do_reset();
        run_to_m1(3);
        tick();
        checks++;
        if (m1_start !== 1'b0 || uart_init !== 1'b0) begin
            errors++; $display("FAIL m1_pulse_len: m1_start=%0b init=%0b want 0/0", m1_start, uart_init);
        end
        repeat (5) tick();
        m1_done = 1'b1; tick(); m1_done = 1'b0;
        checks++;
        if (stage !== 3'd4 || m2_start !== 1'b1) begin
            errors++; $display("FAIL m2_entry: stage=%0d m2_start=%0b want 4/1", stage, m2_start);
        end
        repeat (29) tick();
        m2_done = 1'b1; tick(); m2_done = 1'b0;
        checks++;
        if (stage !== 3'd5 || vga_en !== 1'b1 || error !== 1'b0) begin
            errors++; $display("FAIL vga_entry: stage=%0d vga=%0b err=%0b want 5/1/0", stage, vga_en, error);
        end
        repeat (3) tick();
        checks++;
        if (m1_cnt != 1 || m2_cnt != 1 || init_cnt != 2 || en_cnt != 1 || stage !== 3'd5 || vga_en !== 1'b1) begin
            errors++; $display("FAIL pulse_counts: m1=%0d m2=%0d init=%0d en=%0d stage=%0d want 1/1/2/1/5",
                               m1_cnt, m2_cnt, init_cnt, en_cnt, stage);
        end
    endtask

    task automatic test_ownership();
        do_reset();
        uart_addr = 18'h00010; m1_addr = 18'h00020; m2_addr = 18'h00030; vga_addr = 18'h00040;
        m1_wdata = 16'h1111; m2_wdata = 16'h2222;
        m1_we_n = 1'b0; m2_we_n = 1'b0; #1;
        checks++;
        if (sram_addr !== 18'h0 || sram_we_n !== 1'b1 || sram_wdata !== 16'h0) begin
            errors++; $display("FAIL own_idle: addr=%0h we_n=%0b wdata=%0h want 0/1/0", sram_addr, sram_we_n, sram_wdata);
        end
        start = 1'b1; tick(); start = 1'b0;
        checks++;
        if (sram_addr !== 18'h00010 || sram_we_n !== 1'b1) begin
            errors++; $display("FAIL own_arm: addr=%0h we_n=%0b want 10/1", sram_addr, sram_we_n);
        end
        tick();
        uart_wdata = 16'h5A5A; uart_we_n = 1'b0; #1;
        checks++;
        if (sram_addr !== 18'h00010 || sram_we_n !== 1'b0 || sram_wdata !== 16'h5A5A) begin
            errors++; $display("FAIL own_rx: addr=%0h we_n=%0b wdata=%0h want 10/0/5a5a", sram_addr, sram_we_n, sram_wdata);
        end
        tick(); uart_we_n = 1'b1;
        repeat (8) tick();
        checks++;
        if (stage !== 3'd3 || sram_addr !== 18'h00020 || sram_we_n !== 1'b0 || sram_wdata !== 16'h1111) begin
            errors++; $display("FAIL own_m1: stage=%0d addr=%0h we_n=%0b wdata=%0h want 3/20/0/1111",
                               stage, sram_addr, sram_we_n, sram_wdata);
        end
        m1_done = 1'b1; tick(); m1_done = 1'b0;
        checks++;
        if (stage !== 3'd4 || sram_addr !== 18'h00030 || sram_we_n !== 1'b0 || sram_wdata !== 16'h2222) begin
            errors++; $display("FAIL own_m2: stage=%0d addr=%0h we_n=%0b wdata=%0h want 4/30/0/2222",
                               stage, sram_addr, sram_we_n, sram_wdata);
        end
        m2_done = 1'b1; tick(); m2_done = 1'b0;
        checks++;
        if (stage !== 3'd5 || sram_addr !== 18'h00040 || sram_we_n !== 1'b1 || sram_wdata !== 16'h0) begin
            errors++; $display("FAIL own_vga: stage=%0d addr=%0h we_n=%0b wdata=%0h want 5/40/1/0",
                               stage, sram_addr, sram_we_n, sram_wdata);
        end
    endtask

    task automatic test_watchdog();
        do_reset();
        run_to_m1(1);
        m1_we_n = 1'b0;
        repeat (99) tick();
        checks++;
        if (stage !== 3'd3 || error !== 1'b0) begin
            errors++; $display("FAIL wd_early: stage=%0d err=%0b want 3/0", stage, error);
        end
        tick();
        checks++;
        if (stage !== 3'd6 || error !== 1'b1 || sram_we_n !== 1'b1) begin
            errors++; $display("FAIL wd_expire: stage=%0d err=%0b we_n=%0b want 6/1/1", stage, error, sram_we_n);
        end
        m1_done = 1'b1; tick(); m1_done = 1'b0; tick();
        checks++;
        if (stage !== 3'd6 || error !== 1'b1 || m2_cnt != 0) begin
            errors++; $display("FAIL wd_terminal: stage=%0d err=%0b m2=%0d want 6/1/0", stage, error, m2_cnt);
        end
        do_reset();
        run_to_m1(1);
        repeat (99) tick();
        m1_done = 1'b1; tick(); m1_done = 1'b0;
        checks++;
        if (stage !== 3'd4 || error !== 1'b0 || m2_start !== 1'b1) begin
            errors++; $display("FAIL wd_done_wins: stage=%0d err=%0b m2_start=%0b want 4/0/1", stage, error, m2_start);
        end
    endtask

    task automatic test_stray_events();
        do_reset();
        start = 1'b1; tick(); start = 1'b0; tick();
        repeat (3) tick();
        start = 1'b1; m2_done = 1'b1; m1_done = 1'b1; tick();
        start = 1'b0; m2_done = 1'b0; m1_done = 1'b0;
        repeat (20) tick();
        checks++;
        if (stage !== 3'd2 || init_cnt != 1 || m1_cnt != 0) begin
            errors++; $display("FAIL stray_rx: stage=%0d init=%0d m1=%0d want 2/1/0", stage, init_cnt, m1_cnt);
        end
        uart_we_n = 1'b0; tick(); uart_we_n = 1'b1;
        repeat (8) tick();
        m2_done = 1'b1; tick(); m2_done = 1'b0; tick();
        checks++;
        if (stage !== 3'd3 || m2_cnt != 0 || m1_cnt != 1) begin
            errors++; $display("FAIL stray_m1: stage=%0d m2=%0d m1=%0d want 3/0/1", stage, m2_cnt, m1_cnt);
        end
    endtask

    task automatic test_skip_m2();
        do_reset();
        run_to_m1(2);
        checks++;
        if (b_stage !== 3'd3 || b_m1_start !== 1'b1) begin
            errors++; $display("FAIL skip_m1_entry: stage=%0d m1_start=%0b want 3/1", b_stage, b_m1_start);
        end
        repeat (4) tick();
        m1_done = 1'b1; tick(); m1_done = 1'b0;
        checks++;
        if (b_stage !== 3'd5 || b_vga_en !== 1'b1 || b_m2_start !== 1'b0 || stage !== 3'd4) begin
            errors++; $display("FAIL skip_vga: b_stage=%0d b_vga=%0b b_m2=%0b a_stage=%0d want 5/1/0/4",
                               b_stage, b_vga_en, b_m2_start, stage);
        end
        m2_done = 1'b1; tick(); m2_done = 1'b0; tick();
        checks++;
        if (b_m2_cnt != 0 || b_stage !== 3'd5 || b_error !== 1'b0) begin
            errors++; $display("FAIL skip_no_m2: b_m2_cnt=%0d b_stage=%0d b_err=%0b want 0/5/0", b_m2_cnt, b_stage, b_error);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        run_to_m1(1);
        m1_done = 1'b1; tick(); m1_done = 1'b0;
        m2_we_n = 1'b0; m2_addr = 18'h00033;
        repeat (3) tick();
        #3 rst_n = 1'b0; #1;
        checks++;
        if (stage !== 3'd0 || sram_we_n !== 1'b1 || sram_addr !== 18'h0 || error !== 1'b0 ||
            vga_en !== 1'b0 || m2_start !== 1'b0) begin
            errors++; $display("FAIL async_reset: stage=%0d we_n=%0b addr=%0h err=%0b vga=%0b want 0/1/0/0/0",
                               stage, sram_we_n, sram_addr, error, vga_en);
        end
        tick();
        rst_n = 1'b1; m2_we_n = 1'b1;
        tick();
        checks++;
        if (stage !== 3'd0) begin
            errors++; $display("FAIL reset_hold: stage=%0d want 0", stage);
        end
        start = 1'b1; tick(); start = 1'b0;
        checks++;
        if (stage !== 3'd1 || uart_init !== 1'b1) begin
            errors++; $display("FAIL restart: stage=%0d init=%0b want 1/1", stage, uart_init);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        do_reset();
        test_reset();
        test_happy_path();
        test_ownership();
        test_watchdog();
        test_stray_events();
        test_skip_m2();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
